// File: rtl/serial_receiver_if.sv
`default_nettype none
// serial_receiver_if: serial bit input, parallel req/grant output and error pulses
// of the serial receiver. Rev 1.0
interface serial_receiver_if #(
  parameter int datasize = 32
) ();
  logic                serial_in;
  logic                bit_valid;
  logic                sof;
  logic                ready;
  logic [datasize-1:0] parallel_data_out;
  logic                req;
  logic                grant;
  logic                frame_err;
  logic                overrun;

  // master is the receiver itself; slave is the bit source plus word consumer
  modport master (
    input  serial_in, bit_valid, sof, grant,
    output ready, parallel_data_out, req, frame_err, overrun
  );

  modport slave (
    output serial_in, bit_valid, sof, grant,
    input  ready, parallel_data_out, req, frame_err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// serial_receiver: framed MSB-first serial-to-parallel receiver with one output
// holding register and req/grant hand-off. Rev 1.0
module serial_receiver #(
  parameter int datasize = 32,
  parameter int cntbits  = $clog2(datasize + 1)
) (
  input  logic                 s_clk,
  input  logic                 n_rst,
  serial_receiver_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [cntbits-1:0] LAST_CNT = cntbits'(datasize - 1);
  localparam logic [cntbits-1:0] ONE_CNT  = cntbits'(1);

  state_t              state_q;
  logic [datasize-1:0] shift_q;
  logic [cntbits-1:0]  cnt_q;
  logic [datasize-1:0] pdo_q;
  logic                req_q;
  logic                frame_err_q;
  logic                overrun_q;

  logic                accept_w;
  logic                take_w;
  logic                out_free_w;
  logic [datasize-1:0] word_w;

  assign accept_w   = bus.bit_valid && (state_q != HOLD);
  assign take_w     = req_q && bus.grant;
  assign out_free_w = !req_q || bus.grant;
  assign word_w     = {shift_q[datasize-2:0], bus.serial_in};

  always_ff @(posedge s_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      pdo_q       <= '0;
      req_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= bus.bit_valid && (state_q == HOLD);
      // A load below overrides this release when both happen at one edge
      if (take_w) begin
        req_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept_w) begin
            if (bus.sof) begin
              shift_q <= {{(datasize-1){1'b0}}, bus.serial_in};
              cnt_q   <= ONE_CNT;
              state_q <= SHIFT;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (accept_w) begin
            if (bus.sof) begin
              frame_err_q <= 1'b1;
              shift_q     <= {{(datasize-1){1'b0}}, bus.serial_in};
              cnt_q       <= ONE_CNT;
            end else if (cnt_q == LAST_CNT) begin
              cnt_q <= '0;
              if (out_free_w) begin
                pdo_q   <= word_w;
                req_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                shift_q <= word_w;
                state_q <= HOLD;
              end
            end else begin
              shift_q <= word_w;
              cnt_q   <= cnt_q + ONE_CNT;
            end
          end
        end
        HOLD: begin
          if (take_w) begin
            pdo_q   <= shift_q;
            req_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready             = (state_q != HOLD);
  assign bus.parallel_data_out = pdo_q;
  assign bus.req               = req_q;
  assign bus.frame_err         = frame_err_q;
  assign bus.overrun           = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
// tb_serial_receiver: directed and random stimulus against a word-level
// reference model of the serial receiver. Rev 1.0
module tb_serial_receiver;

  localparam int DS = 32;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;

  serial_receiver_if #(.datasize(DS)) ifc ();

  serial_receiver #(.datasize(DS)) dut (
    .s_clk (clk),
    .n_rst (n_rst),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bit count plus arithmetic accumulation of the frame
  int          m_n;
  logic [63:0] m_val;
  logic        m_held;
  logic [31:0] m_hword;
  logic [31:0] m_out;
  logic        m_req;
  logic        m_fe;
  logic        m_ov;

  logic [35:0] obs;

  function automatic void model_reset();
    m_n     = 0;
    m_val   = '0;
    m_held  = 1'b0;
    m_hword = '0;
    m_out   = '0;
    m_req   = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endfunction

  function automatic void model_update(input logic bv, input logic si, input logic sf, input logic g);
    logic take;
    logic done;
    take = m_req && g;
    done = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (bv && m_held) begin
      m_ov = 1'b1;
    end else if (bv) begin
      if (sf) begin
        if (m_n > 0) m_fe = 1'b1;
        m_val = {63'd0, si};
        m_n   = 1;
      end else if (m_n == 0) begin
        m_fe = 1'b1;
      end else begin
        m_val = m_val * 2 + {63'd0, si};
        m_n   = m_n + 1;
        if (m_n == DS) begin
          done = 1'b1;
          m_n  = 0;
        end
      end
    end
    if (m_held) begin
      if (take) begin
        m_out  = m_hword;
        m_held = 1'b0;
      end
    end else if (done) begin
      if (!m_req || take) begin
        m_out = m_val[31:0];
        m_req = 1'b1;
      end else begin
        m_held  = 1'b1;
        m_hword = m_val[31:0];
      end
    end else if (take) begin
      m_req = 1'b0;
    end
  endfunction

  function automatic logic [35:0] expv();
    return {m_req, !m_held, m_fe, m_ov, m_out};
  endfunction

  task automatic snap();
    obs = {ifc.req, ifc.ready, ifc.frame_err, ifc.overrun, ifc.parallel_data_out};
  endtask

  task automatic step(input logic bv, input logic si, input logic sf, input logic g);
    ifc.bit_valid = bv;
    ifc.serial_in = si;
    ifc.sof       = sf;
    ifc.grant     = g;
    @(posedge clk);
    model_update(bv, si, sf, g);
    #1;
    snap();
  endtask

  task automatic test_reset();
    logic [31:0] w;
    n_rst = 1'b0;
    #2;
    snap();
    n_tests++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), i == 0, 1'b1);
    n_rst = 1'b0;
    model_reset();
    #1;
    snap();
    n_tests++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_midframe: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    w = 32'h5EC0_7A19;
    for (int i = DS - 1; i >= 0; i--) begin
      step(1'b1, w[i], i == DS - 1, 1'b1);
      n_tests++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL reset_refill bit %0d: got %h expected %h", i, obs, expv());
      end
    end
    n_tests++;
    if (ifc.req !== 1'b1 || ifc.parallel_data_out !== 32'h5EC0_7A19) begin
      n_fail++;
      $display("FAIL reset_refill_word: got req=%b data=%h expected req=1 data=5ec07a19", ifc.req, ifc.parallel_data_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'hA5A5_0F3C;
    for (int i = DS - 1; i >= 0; i--) begin
      step(1'b1, w[i], i == DS - 1, 1'b1);
      n_tests++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL single bit %0d: got %h expected %h", i, obs, expv());
      end
    end
    n_tests++;
    if (ifc.req !== 1'b1 || ifc.parallel_data_out !== 32'hA5A5_0F3C) begin
      n_fail++;
      $display("FAIL single_word: got req=%b data=%h expected req=1 data=a5a50f3c", ifc.req, ifc.parallel_data_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (ifc.req !== 1'b0 || obs !== expv()) begin
      n_fail++;
      $display("FAIL single_release: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_sparse();
    logic [31:0] w;
    w = 32'hA5A5_0F3C;
    for (int i = DS - 1; i >= 0; i--) begin
      for (int k = 0; k < 2; k++) begin
        step(1'b0, 1'($urandom), 1'($urandom), 1'b1);
        n_tests++;
        if (obs !== expv()) begin
          n_fail++;
          $display("FAIL sparse_gap bit %0d: got %h expected %h", i, obs, expv());
        end
      end
      step(1'b1, w[i], i == DS - 1, 1'b1);
      n_tests++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL sparse bit %0d: got %h expected %h", i, obs, expv());
      end
    end
    n_tests++;
    if (ifc.req !== 1'b1 || ifc.parallel_data_out !== 32'hA5A5_0F3C) begin
      n_fail++;
      $display("FAIL sparse_word: got req=%b data=%h expected req=1 data=a5a50f3c", ifc.req, ifc.parallel_data_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ws;
    ws = 64'h1111_1111_2222_2222;
    for (int i = 2 * DS - 1; i >= 0; i--) begin
      step(1'b1, ws[i], (i % DS) == DS - 1, 1'b0);
      n_tests++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL b2b bit %0d: got %h expected %h", i, obs, expv());
      end
    end
    n_tests++;
    if (ifc.ready !== 1'b0 || ifc.req !== 1'b1 || ifc.parallel_data_out !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL b2b_hold: got ready=%b req=%b data=%h expected ready=0 req=1 data=11111111", ifc.ready, ifc.req, ifc.parallel_data_out);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (ifc.overrun !== 1'b1 || obs !== expv()) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %h expected %h", obs, expv());
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (ifc.req !== 1'b1 || ifc.ready !== 1'b1 || ifc.overrun !== 1'b0 || ifc.parallel_data_out !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL b2b_grant: got %h expected req=1 ready=1 data=22222222", obs);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (obs !== expv()) begin
      n_fail++;
      $display("FAIL b2b_release: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_sof_restart();
    logic [31:0] a;
    logic [31:0] b;
    logic        saw_req;
    int          fe_count;
    a        = 32'hDEAD_BEEF;
    b        = 32'h3C96_E1F0;
    saw_req  = 1'b0;
    fe_count = 0;
    for (int i = DS - 1; i >= DS - 16; i--) begin
      step(1'b1, a[i], i == DS - 1, 1'b1);
      saw_req  = saw_req | ifc.req;
      fe_count = fe_count + int'(ifc.frame_err);
    end
    for (int i = DS - 1; i >= 0; i--) begin
      step(1'b1, b[i], i == DS - 1, 1'b1);
      n_tests++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL sof_restart bit %0d: got %h expected %h", i, obs, expv());
      end
      if (i > 0) saw_req = saw_req | ifc.req;
      fe_count = fe_count + int'(ifc.frame_err);
    end
    n_tests++;
    if (saw_req !== 1'b0 || fe_count != 1 || ifc.req !== 1'b1 || ifc.parallel_data_out !== 32'h3C96_E1F0) begin
      n_fail++;
      $display("FAIL sof_restart_word: got early_req=%b fe=%0d data=%h expected early_req=0 fe=1 data=3c96e1f0", saw_req, fe_count, ifc.parallel_data_out);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_idle_noise();
    int fe_count;
    fe_count = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom), 1'b0, 1'b0);
      fe_count = fe_count + int'(ifc.frame_err);
      n_tests++;
      if (obs !== expv() || ifc.req !== 1'b0 || ifc.frame_err !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_noise %0d: got %h expected %h", i, obs, expv());
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (fe_count != 5 || ifc.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_noise_count: got %0d pulses fe=%b expected 5 pulses fe=0", fe_count, ifc.frame_err);
    end
  endtask

  task automatic test_random();
    logic bv;
    logic sf;
    for (int c = 0; c < 4000; c++) begin
      bv = ($urandom_range(0, 3) != 0);
      sf = (m_n == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      step(bv, 1'($urandom), sf, 1'($urandom_range(0, 2) == 0));
      n_tests++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", c, obs, expv());
      end
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    n_rst         = 1'b0;
    ifc.serial_in = 1'b0;
    ifc.bit_valid = 1'b0;
    ifc.sof       = 1'b0;
    ifc.grant     = 1'b0;
    obs           = '0;
    model_reset();
    test_reset();
    test_single();
    test_sparse();
    test_back_to_back();
    test_sof_restart();
    test_idle_noise();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_receiver.md
# serial_receiver

Serial-to-parallel receiver: the return-direction counterpart of the parallel-to-serial path. It samples a framed, MSB-first bit stream in the s_clk domain and assembles `datasize`-bit words. It hands each word to a parallel consumer over a req/grant handshake, and back-pressures the bit source with `ready`. Buffering is two words: the shift register plus one output holding register.

## Interface
Parameters:
- datasize, 32, word width in bits; supported range is ≥2.
- cntbits, $clog2(datasize+1), width of the bit counter; derived, not overridden.

Ports:
- s_clk  in  1  receive clock; all state changes on its rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies serial_in for the current cycle.
- sof  in  1  start of frame; marks the MSB of a word; meaningful only with bit_valid.
- ready  out  1  receiver can accept a bit this cycle.
- parallel_data_out  out  datasize  assembled word; stable while req=1.
- req  out  1  word available in the output register.
- grant  in  1  consumer takes the word at this edge when req=1.
- frame_err  out  1  one-cycle pulse on a framing violation.
- overrun  out  1  one-cycle pulse when a bit is dropped because ready=0.

## Operation
- Reset (n_rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - parallel_data_out=0, req=0, frame_err=0, overrun=0.
  - ready=1, since ready is decoded from state.
- A bit is accepted when bit_valid=1 and ready=1.
- Bits are MSB first: the sof bit lands in bit datasize-1.
- States:
  - IDLE:
    - Accepted bit with sof=1: shift in the bit, counter=1, go to SHIFT.
    - Accepted bit with sof=0: discard the bit and pulse frame_err.
  - SHIFT:
    - Accepted bit with sof=0: shift left, insert the bit at the LSB, counter+1.
    - Accepted bit with sof=1: pulse frame_err, discard the partial word, restart with this bit as the MSB (counter=1).
    - Word completion: the edge that accepts bit number datasize. At that edge:
      - If the output register is free (req=0, or req=1 and grant=1): parallel_data_out loads {shift, bit}, req=1, go to IDLE.
      - Otherwise: the shift register keeps the full word, go to HOLD.
  - HOLD:
    - ready=0.
    - On req=1 and grant=1: parallel_data_out loads the shift register, req stays 1, go to IDLE.
- ready = (state != HOLD).
- overrun: pulses for any bit_valid=1 while ready=0. The bit is ignored and sof is ignored with it.
- Output handshake:
  - req=1 and grant=1 at an edge with no new word loaded: req→0.
  - grant while req=0 is ignored.
  - parallel_data_out is never modified while req=1, except by a load at a grant edge.
- frame_err and overrun are registered: they are high for exactly the one cycle after the offending edge.

## Timing
- Latency: last bit sampled at edge k → req=1 and valid data in the cycle after k.
- Sustained throughput is one bit per cycle with grant held high. No bubble between words: the next sof may arrive in the cycle immediately after the last bit.
- HOLD exit: grant at edge g → ready=1 in the cycle after g. The first bit of the next word may be accepted at edge g+1.
- Simultaneous events at one edge:
  - Word completion plus grant of the previous word: the new word is loaded and req stays 1.
  - sof in SHIFT on the final bit position: treated as a restart, not a completion.
- Reset asserted mid-frame or mid-HOLD: all state is discarded with no partial-word output. req drops asynchronously.
- The counter never exceeds datasize. There is no wrap; the counter reloads to 1 on sof.

## Test plan
- Reset mid-frame: 10 bits accepted, then n_rst=0 for 2 cycles → req=0, parallel_data_out=0, ready=1. A new 32-bit frame then yields exactly that word.
- Single word 0xA5A50F3C, bit_valid every cycle, grant=1 → req=1 in the cycle after the 32nd bit with data=0xA5A50F3C. req=0 one cycle later.
- Same word with bit_valid every 3rd cycle and random serial_in on invalid cycles → data=0xA5A50F3C, and req only after the 32nd valid bit.
- Back-to-back words 0x11111111 and 0x22222222, grant=0:
  - First word in the output register; second word completes → HOLD, ready=0.
  - An extra bit_valid → overrun pulse, no state change.
  - grant pulse → data=0x22222222, req stays 1, ready=1 the next cycle.
- sof reasserted on bit 17 of a frame → one frame_err pulse and no req. The next 31 bits complete the word that began at the second sof.
- 5 bit_valid cycles with sof=0 from IDLE → 5 frame_err pulses, req stays 0, state stays IDLE.
